// File: rtl/wfg_capture_mem_pkg.sv
// Shared types and constants for the waveform-generator capture memory writer.
// Holds the FSM state encoding and the 17-bit address step helper.
package wfg_capture_mem_pkg;

    localparam int          ADDR_W    = 10;
    localparam int          DATA_W    = 32;
    localparam int          PTR_W     = 16;
    localparam int          INC_W     = 8;
    localparam logic [3:0]  FULL_MASK = 4'hF;

    typedef enum logic [1:0] {
        CAP_ST_IDLE  = 2'd0,
        CAP_ST_ARMED = 2'd1,
        CAP_ST_WRITE = 2'd2,
        CAP_ST_DONE  = 2'd3
    } wfg_capture_mem_states_t;

    typedef struct packed {
        logic             past_end;
        logic [PTR_W-1:0] addr;
    } addr_step_t;

    // The sum is kept at 17 bits so a step past 16'hFFFF counts as past the end
    // instead of silently folding back to a small address.
    function automatic addr_step_t next_addr(
        input logic [PTR_W-1:0] cur,
        input logic [INC_W-1:0] inc,
        input logic [PTR_W-1:0] end_val
    );
        logic [PTR_W:0] sum;
        addr_step_t     res;
        sum          = {1'b0, cur} + {{(PTR_W+1-INC_W){1'b0}}, inc};
        res.past_end = (sum > {1'b0, end_val});
        res.addr     = sum[PTR_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/wfg_capture_mem_if.sv
// AXI-Stream sample bus feeding the capture memory writer.
interface wfg_capture_mem_if;
    import wfg_capture_mem_pkg::*;

    logic              wfg_axis_tvalid;
    logic              wfg_axis_tready;
    logic [DATA_W-1:0] wfg_axis_tdata;

    modport master (
        output wfg_axis_tvalid,
        output wfg_axis_tdata,
        input  wfg_axis_tready
    );

    modport slave (
        input  wfg_axis_tvalid,
        input  wfg_axis_tdata,
        output wfg_axis_tready
    );

endinterface

// File: rtl/wfg_capture_mem.sv
// Stream sink writing each accepted beat to SRAM at START..END in INC steps.
// Define WFG_CAPTURE_MEM_ONESHOT_EN to stop at the end address instead of wrapping.
module wfg_capture_mem
    import wfg_capture_mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    wfg_capture_mem_if.slave    wfg_axis,
    input  logic                ctrl_en_q_i,
    input  logic [PTR_W-1:0]    start_val_q_i,
    input  logic [PTR_W-1:0]    end_val_q_i,
    input  logic [INC_W-1:0]    inc_val_q_i,
    output logic                done_o,
    output logic [PTR_W-1:0]    count_o,
    output logic                csb0,
    output logic                web0,
    output logic [3:0]          wmask0,
    output logic [ADDR_W-1:0]   addr0,
    output logic [DATA_W-1:0]   din0
);

    localparam logic [1:0] ST_IDLE  = CAP_ST_IDLE;
    localparam logic [1:0] ST_ARMED = CAP_ST_ARMED;
    localparam logic [1:0] ST_WRITE = CAP_ST_WRITE;
    localparam logic [1:0] ST_DONE  = CAP_ST_DONE;

    logic [1:0]        r_state;
    logic [PTR_W-1:0]  r_cur_address;
    logic [DATA_W-1:0] r_data;
    logic [PTR_W-1:0]  r_count;

    logic [1:0]        w_state_next;
    logic [PTR_W-1:0]  w_cur_address_next;
    logic [PTR_W-1:0]  w_count_next;
    logic              w_tready;
    logic              w_handshake;
    logic              w_writing;
    addr_step_t        w_step;

    // tready never looks at tvalid, so upstream may wait on it freely.
    assign w_tready    = (r_state == ST_ARMED) & ctrl_en_q_i;
    assign w_handshake = w_tready & wfg_axis.wfg_axis_tvalid;
    assign w_writing   = (r_state == ST_WRITE);
    assign w_step      = next_addr(r_cur_address, inc_val_q_i, end_val_q_i);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ctrl_en_q_i) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!ctrl_en_q_i) begin
                    w_state_next = ST_IDLE;
                end else if (w_handshake) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!ctrl_en_q_i) begin
                    w_state_next = ST_IDLE;
                end else if (w_step.past_end) begin
`ifdef WFG_CAPTURE_MEM_ONESHOT_EN
                    w_state_next = ST_DONE;
`else
                    w_state_next = ST_ARMED;
`endif
                end else begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_DONE: begin
                if (!ctrl_en_q_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The base is only reloaded in idle; register edits while armed apply at the next step.
    always_comb begin
        w_cur_address_next = r_cur_address;
        if (r_state == ST_IDLE) begin
            w_cur_address_next = start_val_q_i;
        end else if (w_writing) begin
            w_cur_address_next = w_step.past_end ? start_val_q_i : w_step.addr;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (r_state == ST_IDLE) begin
            w_count_next = '0;
        end else if (w_writing && (r_count != {PTR_W{1'b1}})) begin
            w_count_next = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cur_address <= start_val_q_i;
            r_data        <= '0;
            r_count       <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cur_address <= w_cur_address_next;
            r_count       <= w_count_next;
            if (w_handshake) begin
                r_data <= wfg_axis.wfg_axis_tdata;
            end
        end
    end

    // SRAM strobes decode straight from state; address and data are registers,
    // so both are stable for the whole write cycle.
    assign wfg_axis.wfg_axis_tready = w_tready;
    assign csb0    = ~w_writing;
    assign web0    = ~w_writing;
    assign wmask0  = FULL_MASK;
    assign addr0   = r_cur_address[ADDR_W-1:0];
    assign din0    = r_data;
    assign count_o = r_count;

`ifdef WFG_CAPTURE_MEM_ONESHOT_EN
    assign done_o = (r_state == ST_DONE);
`else
    assign done_o = 1'b0;
`endif

endmodule

// File: tb/tb_wfg_capture_mem.sv
// Directed bench for wfg_capture_mem: table of beats plus hand-written corner sequences.
module tb_wfg_capture_mem;
    import wfg_capture_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] start_v;
    logic [15:0] end_v;
    logic [7:0]  inc_v;
    logic        done_o;
    logic [15:0] count_o;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [9:0]  addr0;
    logic [31:0] din0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    wfg_capture_mem_if axis_if ();

    wfg_capture_mem dut (
        .clk           (clk),
        .rst           (rst),
        .wfg_axis      (axis_if),
        .ctrl_en_q_i   (en),
        .start_val_q_i (start_v),
        .end_val_q_i   (end_v),
        .inc_val_q_i   (inc_v),
        .done_o        (done_o),
        .count_o       (count_o),
        .csb0          (csb0),
        .web0          (web0),
        .wmask0        (wmask0),
        .addr0         (addr0),
        .din0          (din0)
    );

    always #5 clk = ~clk;

    // Each write cycle contains exactly one falling edge.
    always @(negedge clk) begin
        if (!csb0 && !web0) n_writes <= n_writes + 1;
    end

    typedef struct {
        bit          restart;
        logic [15:0] start_v;
        logic [15:0] end_v;
        logic [7:0]  inc_v;
        logic [31:0] data;
        logic [9:0]  exp_addr;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic restart(input logic [15:0] s, input logic [15:0] e, input logic [7:0] inc);
        en      = 1'b0;
        start_v = s;
        end_v   = e;
        inc_v   = inc;
        tick();
        tick();
        en = 1'b1;
        tick();
    endtask

    task automatic send_beat(input string tag, input logic [31:0] data, input logic [9:0] exp_addr,
                             input logic [15:0] exp_count, input logic exp_ready_after);
        for (int k = 0; k < 20 && axis_if.wfg_axis_tready !== 1'b1; k++) tick();
        chk({tag, " tready before beat"}, axis_if.wfg_axis_tready, 1);
        axis_if.wfg_axis_tvalid = 1'b1;
        axis_if.wfg_axis_tdata  = data;
        tick();
        axis_if.wfg_axis_tvalid = 1'b0;
        chk({tag, " csb0 in write"}, csb0, 0);
        chk({tag, " web0 in write"}, web0, 0);
        chk({tag, " wmask0"}, wmask0, 4'hF);
        chk({tag, " addr0"}, addr0, exp_addr);
        chk({tag, " din0"}, din0, data);
        chk({tag, " tready in write"}, axis_if.wfg_axis_tready, 0);
        tick();
        chk({tag, " count_o"}, count_o, exp_count);
        chk({tag, " tready after write"}, axis_if.wfg_axis_tready, exp_ready_after);
        $display("beat %s: data=%h addr0=%h count=%0d", tag, data, exp_addr, count_o);
    endtask

    initial begin
        int p;
        vecs[0]  = '{1'b1, 16'h0000, 16'h0006, 8'd2,   32'hA000_0000, 10'h000, 16'd1};
        vecs[1]  = '{1'b0, 16'h0000, 16'h0006, 8'd2,   32'hA000_0001, 10'h002, 16'd2};
        vecs[2]  = '{1'b0, 16'h0000, 16'h0006, 8'd2,   32'hA000_0002, 10'h004, 16'd3};
        vecs[3]  = '{1'b0, 16'h0000, 16'h0006, 8'd2,   32'hA000_0003, 10'h006, 16'd4};
        vecs[4]  = '{1'b0, 16'h0000, 16'h0006, 8'd2,   32'hA000_0004, 10'h000, 16'd5};
        vecs[5]  = '{1'b1, 16'hFFF0, 16'hFFFF, 8'd255, 32'hB000_0000, 10'h3F0, 16'd1};
        vecs[6]  = '{1'b0, 16'hFFF0, 16'hFFFF, 8'd255, 32'hB000_0001, 10'h3F0, 16'd2};
        vecs[7]  = '{1'b1, 16'h0005, 16'h0009, 8'd0,   32'hC000_0000, 10'h005, 16'd1};
        vecs[8]  = '{1'b0, 16'h0005, 16'h0009, 8'd0,   32'hC000_0001, 10'h005, 16'd2};
        vecs[9]  = '{1'b1, 16'h0014, 16'h0003, 8'd1,   32'hD000_0000, 10'h014, 16'd1};
        vecs[10] = '{1'b0, 16'h0014, 16'h0003, 8'd1,   32'hD000_0001, 10'h014, 16'd2};
        vecs[11] = '{1'b1, 16'h0000, 16'h0064, 8'd4,   32'hE000_0000, 10'h000, 16'd1};
        vecs[12] = '{1'b0, 16'h0000, 16'h0064, 8'd4,   32'hE000_0001, 10'h004, 16'd2};
        vecs[13] = '{1'b0, 16'h0000, 16'h0064, 8'd10,  32'hE000_0002, 10'h008, 16'd3};
        vecs[14] = '{1'b0, 16'h0000, 16'h0064, 8'd10,  32'hE000_0003, 10'h012, 16'd4};

        rst = 1'b1;
        en = 1'b0;
        start_v = 16'h0123;
        end_v = 16'h0000;
        inc_v = 8'd0;
        axis_if.wfg_axis_tvalid = 1'b0;
        axis_if.wfg_axis_tdata  = '0;
        tick();
        tick();
        chk("reset tready", axis_if.wfg_axis_tready, 0);
        chk("reset csb0", csb0, 1);
        chk("reset web0", web0, 1);
        chk("reset wmask0", wmask0, 4'hF);
        chk("reset addr0", addr0, 10'h123);
        chk("reset din0", din0, 0);
        chk("reset done_o", done_o, 0);
        chk("reset count_o", count_o, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].restart) begin
                restart(vecs[i].start_v, vecs[i].end_v, vecs[i].inc_v);
            end else begin
                start_v = vecs[i].start_v;
                end_v   = vecs[i].end_v;
                inc_v   = vecs[i].inc_v;
            end
            send_beat($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_addr, vecs[i].exp_count, 1'b1);
            chk($sformatf("vec%0d done_o", i), done_o, 0);
        end

        // Idle stream: no strobes and the address holds at 18 + 10.
        p = n_writes;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("gap tready", axis_if.wfg_axis_tready, 1);
        end
        chk("gap write count", n_writes, p);
        chk("gap addr0", addr0, 10'h01C);
        $display("gap: writes=%0d addr0=%h", n_writes - p, addr0);

        // Disable while the write is in flight.
        axis_if.wfg_axis_tvalid = 1'b1;
        axis_if.wfg_axis_tdata  = 32'hF00D_0001;
        tick();
        axis_if.wfg_axis_tvalid = 1'b0;
        en = 1'b0;
        p = n_writes;
        chk("disable csb0 in write", csb0, 0);
        chk("disable din0", din0, 32'hF00D_0001);
        tick();
        chk("disable write happened", n_writes, p + 1);
        chk("disable tready", axis_if.wfg_axis_tready, 0);
        chk("disable csb0 after", csb0, 1);
        tick();
        chk("disable count cleared", count_o, 0);
        en = 1'b1;
        tick();
        chk("reenable tready", axis_if.wfg_axis_tready, 1);
        chk("reenable addr0", addr0, 10'h000);
        chk("reenable count", count_o, 0);
        $display("disable: write kept, restart addr0=%h count=%0d", addr0, count_o);

        // Reset while writing.
        axis_if.wfg_axis_tvalid = 1'b1;
        axis_if.wfg_axis_tdata  = 32'hF00D_0002;
        tick();
        axis_if.wfg_axis_tvalid = 1'b0;
        chk("rst-in-write csb0 before", csb0, 0);
        rst = 1'b1;
        tick();
        chk("rst-in-write csb0", csb0, 1);
        chk("rst-in-write web0", web0, 1);
        chk("rst-in-write done_o", done_o, 0);
        chk("rst-in-write count_o", count_o, 0);
        chk("rst-in-write tready", axis_if.wfg_axis_tready, 0);
        rst = 1'b0;
        $display("reset during write: csb0=%b count=%0d", csb0, count_o);

`ifdef WFG_CAPTURE_MEM_ONESHOT_EN
        restart(16'd10, 16'd12, 8'd1);
        send_beat("os0", 32'h1111_0000, 10'h00A, 16'd1, 1'b1);
        send_beat("os1", 32'h1111_0001, 10'h00B, 16'd2, 1'b1);
        send_beat("os2", 32'h1111_0002, 10'h00C, 16'd3, 1'b0);
        chk("oneshot done_o", done_o, 1);
        p = n_writes;
        axis_if.wfg_axis_tvalid = 1'b1;
        axis_if.wfg_axis_tdata  = 32'h1111_0003;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("oneshot stall tready", axis_if.wfg_axis_tready, 0);
        end
        axis_if.wfg_axis_tvalid = 1'b0;
        chk("oneshot no extra write", n_writes, p);
        chk("oneshot count held", count_o, 3);
        chk("oneshot done held", done_o, 1);
        en = 1'b0;
        tick();
        chk("oneshot done cleared", done_o, 0);
        $display("oneshot: done released after disable");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wfg_capture_mem.md
# wfg_capture_mem

AXI-Stream sink that records incoming 32-bit samples into the single-port SRAM used by the waveform generator. It is the write-side counterpart of the stimulus memory reader. It accepts beats on a slave stream and writes each one to an address walked from START.VAL to END.VAL in INC.VAL steps. It sits between an upstream stream source (for example a loop-back or capture path) and the SRAM write port.

## Interface
Parameters: none; all widths are fixed.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- wfg_axis_tready_o  output  1  slave ready.
- wfg_axis_tvalid_i  input  1  slave valid.
- wfg_axis_tdata_i  input  32  sample data.
- ctrl_en_q_i  input  1  enable. Deasserting it aborts the capture and returns the block to idle.
- start_val_q_i  input  16  first write address.
- end_val_q_i  input  16  last allowed address, inclusive.
- inc_val_q_i  input  8  address increment.
- done_o  output  1  one-shot capture complete; see Configuration.
- count_o  output  16  beats written since enable; saturates at 16'hFFFF.
- csb0  output  1  SRAM chip select, active-low.
- web0  output  1  SRAM write enable, active-low.
- wmask0  output  4  byte mask; always 4'hF.
- addr0  output  10  SRAM address = cur_address[9:0].
- din0  output  32  SRAM write data = latched sample.

## Operation
- States:
  - ST_IDLE: waits for enable.
  - ST_ARMED: waits for a beat.
  - ST_WRITE: issues the SRAM write.
  - ST_DONE: one-shot capture complete.
- ST_IDLE:
  - Every cycle: cur_address <= start_val_q_i and count <= 0.
  - If ctrl_en_q_i = 1, go to ST_ARMED.
- ST_ARMED:
  - wfg_axis_tready_o = 1.
  - On tvalid & tready: data <= tdata_i, then go to ST_WRITE.
- ST_WRITE:
  - csb0 = 0 and web0 = 0 for exactly this cycle; the SRAM captures at the closing edge.
  - Address update:
    - sum = {1'b0, cur_address} + inc_val_q_i, computed in 17 bits with no truncation.
    - If sum > end_val_q_i, the end is reached: wrap mode sets cur_address <= start_val_q_i and returns to ST_ARMED; one-shot mode goes to ST_DONE.
    - Otherwise cur_address <= sum[15:0] and return to ST_ARMED.
  - count increments, saturating.
- ST_DONE:
  - done_o = 1 and tready = 0.
  - Stays here until ctrl_en_q_i = 0.
- Disable: ctrl_en_q_i = 0 in any non-idle state forces next_state = ST_IDLE.
  - A write already in ST_WRITE still completes in that cycle.
  - No new beat is accepted: tready = (state == ST_ARMED) & ctrl_en_q_i.
- Boundary cases:
  - inc_val_q_i = 0: every beat rewrites start_val_q_i.
  - start_val_q_i > end_val_q_i: the first write lands at start, then the block wraps or finishes.
  - Register changes while enabled take effect at the next ST_WRITE; the cur_address base is not reloaded.
- Addresses above 10 bits are truncated on addr0. Comparison and wrap use the full 16 bits.

## Timing
- Reset values: state ST_IDLE, tready 0, csb0 1, web0 1, wmask0 4'hF, addr0 start_val_q_i[9:0] (registered at reset), din0 0, done_o 0, count_o 0.
- Handshake at edge N in ST_ARMED → ST_WRITE during cycle N+1 → SRAM write at edge N+2 → ST_ARMED again in cycle N+2.
- Throughput: one beat per 2 cycles; tready is low during ST_WRITE.
- tready depends only on state and ctrl_en_q_i, never on tvalid.
- Memory controls are combinational decodes of state. addr0 and din0 are stable throughout ST_WRITE.
- Reset asserted mid-write: state returns to ST_IDLE at that edge and csb0/web0 are 1 from the next cycle.

## Configuration
- WFG_CAPTURE_MEM_ONESHOT_EN defined:
  - When the end is reached, the block goes to ST_DONE and holds done_o = 1 until disabled.
- Not defined:
  - The address always wraps to start_val_q_i.
  - ST_DONE is unreachable and done_o is tied to 0.

## Structure
- Package wfg_capture_mem_pkg holds:
  - the typedef enum wfg_capture_mem_states_t;
  - localparams for the address width (10), data width (32) and full mask (4'hF).
- No sub-module. Capture FSM, address generator and counter live in one file.

## Test plan
- Wrap mode: start 0, end 6, inc 2, 5 back-to-back beats A0..A4 → writes A0@0, A1@2, A2@4, A3@6, A4@0; tready toggles 1/0; count_o = 5.
- One-shot (macro on): start 10, end 12, inc 1, 4 beats → writes at 10, 11, 12; done_o = 1 two cycles after the third handshake; fourth beat stalls (tready = 0); count_o = 3.
- Overflow: start 16'hFFF0, end 16'hFFFF, inc 255 → second beat wraps to 16'hFFF0 (17-bit sum), with no write to a truncated small address.
- tvalid gaps: tvalid low for 3 cycles in ST_ARMED → no csb0 pulse, tready stays 1, address unchanged.
- Disable during ST_WRITE → that write occurs; the next cycle is ST_IDLE with tready 0; re-enable restarts at start_val_q_i with count_o = 0.
- Reset asserted while in ST_WRITE → next cycle csb0 = web0 = 1, done_o = 0, count_o = 0.
